scroll_window: RTL
==================

# scroll_window

Parametrised scrolling symbol window for the board display path. Holds a writable circular message buffer of DEPTH symbols and presents a DIGITS-wide window into it, advancing the window start (head) left or right on an internal prescaled tick or a manual step pulse. It sits between the control logic that loads message content and the seven-segment/hex decoder that renders `display`. Post-reset contents reproduce the plain hex-count scroll (0123, 1234, ...), with correct modulo wrap.

## Interface
- DIGITS, 4, window width in symbols (≥1)
- SYM_W, 4, bits per symbol
- DEPTH, 16, message buffer entries (≥2); AW = $clog2(DEPTH)
- PRESCALE, 50_000_000, clk cycles per automatic step (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  automatic stepping enable
- dir  in  1  0 = scroll left (head+1), 1 = scroll right (head−1)
- step  in  1  manual single-step request, honoured regardless of en
- len  in  AW+1  active message length L; 0 or >DEPTH means L = DEPTH
- wr_en  in  1  buffer write strobe
- wr_addr  in  AW  write address; addresses ≥DEPTH ignored
- wr_data  in  SYM_W  write symbol
- display  out  DIGITS*SYM_W  window; leftmost digit in MSBs
- head  out  AW  current window start index
- stepped  out  1  one-cycle pulse: head advanced on previous edge

## Operation
- Reset: buf[i] = i mod 2^SYM_W, head = 0, prescaler = 0, stepped = 0, display = window of reset buffer at head 0 with L = DEPTH (defaults: 16'h0123).
- Prescaler counts 0..PRESCALE−1 while en=1; tick asserted in the cycle count = PRESCALE−1, count then returns to 0. en=0 clears count to 0, no tick.
- Step event = tick OR step. Coincident tick and step give exactly one advance.
- On step event: dir=0 → head = (head+1 == L) ? 0 : head+1; dir=1 → head = (head == 0) ? L−1 : head−1. stepped <= 1 on that edge, else 0.
- Out-of-range head: if head ≥ L (len reduced), head <= 0 on next edge, takes priority over any step event, stepped stays 0.
- Window: digit position k (k=0 leftmost, bits [(DIGITS−1−k)*SYM_W +: SYM_W]) = buf[(head+k) mod L]. True modulo required; DIGITS > L repeats the message (L=1 fills all digits with buf[0]).
- Writes: wr_en with wr_addr < DEPTH updates buf[wr_addr] on the edge; entries ≥ L are retained but not displayed.
- Reset mid-operation: all state returns to reset values on the edge, including buffer contents.

## Timing
- display is registered from current head, buffer and len: changes one edge after a head update or write, i.e. in the same cycle as stepped is low again (stepped high cycle still shows old window).
- Write and display of the same address: new symbol appears at display two edges after wr_en sampled (write edge + display edge).
- len change affects display one edge later; head correction (if needed) lands on the first edge after the change.
- Auto step period exactly PRESCALE cycles while en held high; first tick PRESCALE cycles after en rises.
- No combinational path from any input to any output.

## Structure
- Package scroll_pkg: dir encoding constants (SCROLL_LEFT=0, SCROLL_RIGHT=1), a wrap_inc/wrap_dec helper function, and the effective-length function (len → L).
- Sub-module scroll_prescaler (PRESCALE parameter, clk/rst/en in, tick out) — the only natural split; buffer, head and window logic stay in scroll_window.

## Test plan
- Reset with defaults, PRESCALE=4: display=16'h0123, head=0, stepped=0; hold rst mid-scroll → same values next edge.
- en=1, dir=0, len=16: stepped every 4 cycles; after 13 steps head=13, display=16'hDEF0; after 16 steps head=0, display=16'h0123.
- From head 0, dir=1, one step: head=15, display=16'hF012.
- len=3, DIGITS=4: head 0 display=16'h0120; head sequence 0,1,2,0; head 2 display=16'h2012. With head=10, set len=8 → head=0 next edge, stepped=0.
- en=0, step pulses: one advance per pulse; step coincident with tick (en=1) → head advances by exactly 1.
- Head 0, write wr_addr=1 wr_data=4'hA → display=16'h0A23 two edges later; write wr_addr=12 with len=8 → display unchanged.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared definitions for the scrolling symbol window: scroll direction
// encoding, circular index helpers and the effective message length rule.
package scroll_pkg;

    localparam logic SCROLL_LEFT  = 1'b0;
    localparam logic SCROLL_RIGHT = 1'b1;

    function automatic int wrap_inc(input int idx, input int len_eff);
        return (idx + 1 == len_eff) ? 0 : idx + 1;
    endfunction

    function automatic int wrap_dec(input int idx, input int len_eff);
        return (idx == 0) ? len_eff - 1 : idx - 1;
    endfunction

    // A length of zero or anything beyond the buffer means "use the whole buffer".
    function automatic int eff_len(input int len_in, input int depth);
        return (len_in == 0 || len_in > depth) ? depth : len_in;
    endfunction

endpackage

// File: rtl/scroll_prescaler.sv
// Free-running divider producing a one-cycle tick every PRESCALE clocks while
// enabled; dropping the enable restarts the count from zero.
module scroll_prescaler #(
    parameter int PRESCALE = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == CW'(PRESCALE - 1));
    assign tick   = en && w_last;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/scroll_window.sv
// Circular message buffer with a DIGITS-wide registered window whose start
// index advances on a prescaled tick or a manual step pulse.
module scroll_window
    import scroll_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SYM_W    = 4,
    parameter int DEPTH    = 16,
    parameter int PRESCALE = 50_000_000,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    dir,
    input  logic                    step,
    input  logic [AW:0]             len,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [SYM_W-1:0]        wr_data,
    output logic [DIGITS*SYM_W-1:0] display,
    output logic [AW-1:0]           head,
    output logic                    stepped
);

    logic [SYM_W-1:0]        r_buf [DEPTH];
    logic [AW-1:0]           r_head;
    logic                    r_stepped;
    logic [DIGITS*SYM_W-1:0] r_display;

    logic                    w_tick;
    logic                    w_event;
    int                      w_len;
    logic                    w_head_oob;
    logic [AW-1:0]           w_head_next;
    logic [DIGITS*SYM_W-1:0] w_window;
    logic [DIGITS*SYM_W-1:0] w_reset_window;

    scroll_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(w_tick)
    );

    assign w_event = w_tick || step;

    always_comb begin
        w_len       = eff_len(int'(len), DEPTH);
        w_head_oob  = (int'(r_head) >= w_len);
        w_head_next = (dir == SCROLL_RIGHT) ? AW'(wrap_dec(int'(r_head), w_len))
                                            : AW'(wrap_inc(int'(r_head), w_len));
    end

    // True modulo so windows wider than the message repeat it.
    always_comb begin
        w_window       = '0;
        w_reset_window = '0;
        for (int k = 0; k < DIGITS; k++) begin
            int idx;
            idx = (int'(r_head) + k) % w_len;
            w_window[(DIGITS-1-k)*SYM_W +: SYM_W]       = r_buf[AW'(idx)];
            w_reset_window[(DIGITS-1-k)*SYM_W +: SYM_W] = SYM_W'(k % DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= SYM_W'(i);
            end
        end else if (wr_en && int'(wr_addr) < DEPTH) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // A shortened message pulls an out-of-range head home before any step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_stepped <= 1'b0;
        end else if (w_head_oob) begin
            r_head    <= '0;
            r_stepped <= 1'b0;
        end else if (w_event) begin
            r_head    <= w_head_next;
            r_stepped <= 1'b1;
        end else begin
            r_stepped <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_display <= w_reset_window;
        end else begin
            r_display <= w_window;
        end
    end

    assign display = r_display;
    assign head    = r_head;
    assign stepped = r_stepped;

endmodule
